// File: rtl/dot_product_layer_unit.sv
// dot_product_layer_unit
//   Fixed-point dense-layer engine: NUM_UNITS lanes each accumulate a signed
//   dot product over `length` operand beats, then add a per-lane bias,
//   rescale, apply an activation and saturate into result_out.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   start, length,    operation request and its configuration; the
//   act_mode,         configuration is captured when start is taken in IDLE
//   active_units,
//   bias_array
//   a_in_array,       per-lane operands of one beat, handshaked by
//   b_in_array,       a_valid / a_ready
//   a_valid, a_ready
//   result_out,       per-lane results, handshaked by out_valid / out_ready
//   out_valid,
//   out_ready
//   busy              high whenever the FSM is outside IDLE
//   done              high in the cycle the result is accepted
//   err               one-cycle pulse after a start with an illegal length

// Per-lane datapath: accumulator, bias/rescale, activation, saturation.
module dot_product_lane #(
    parameter int WIDTH     = 16,
    parameter int MAX_LEN   = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,     // capture enable/bias, clear acc
    input  logic                    en,
    input  logic        [WIDTH-1:0] bias_in,
    input  logic                    acc_en,   // accepted beat
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    finish,   // produce the result this cycle
    input  logic              [1:0] mode,
    output logic        [WIDTH-1:0] result
);
    localparam int ACC_W = 2*WIDTH + $clog2(MAX_LEN) + 1;
    // One extra bit so the bias addition can never overflow.
    localparam int SW    = ACC_W + 1;

    logic                    en_q;
    logic        [WIDTH-1:0] bias_q;
    logic        [ACC_W-1:0] acc_q;
    logic        [WIDTH-1:0] result_q;

    logic signed [2*WIDTH-1:0] prod;
    logic signed [SW-1:0]      bias_ext, sum, shr, act, max_v, min_v;
    logic        [WIDTH-1:0]   sat_d;

    assign prod  = a * b;
    assign max_v = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    assign min_v = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    always_comb begin
        bias_ext = $signed({{(SW-WIDTH){bias_q[WIDTH-1]}}, bias_q}) <<< FRAC_BITS;
        sum      = $signed({acc_q[ACC_W-1], acc_q}) + bias_ext;
        // Arithmetic shift: truncation toward -inf.
        shr      = sum >>> FRAC_BITS;
        case (mode)
            2'd1:    act = shr[SW-1] ? '0 : shr;
            2'd2:    act = shr[SW-1] ? (shr >>> 3) : shr;
            default: act = shr;
        endcase
        if (act > max_v)      sat_d = max_v[WIDTH-1:0];
        else if (act < min_v) sat_d = min_v[WIDTH-1:0];
        else                  sat_d = act[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q     <= 1'b0;
            bias_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            if (load) begin
                en_q   <= en;
                bias_q <= bias_in;
                acc_q  <= '0;
            end else if (acc_en && en_q) begin
                acc_q <= acc_q + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
            end
            if (finish)
                result_q <= en_q ? sat_d : '0;
        end
    end

    assign result = result_q;
endmodule

module dot_product_layer_unit #(
    parameter int WIDTH     = 16,
    parameter int NUM_UNITS = 16,
    parameter int MAX_LEN   = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [$clog2(MAX_LEN):0]            length,
    input  logic [1:0]                          act_mode,
    input  logic [NUM_UNITS-1:0]                active_units,
    input  logic [NUM_UNITS-1:0][WIDTH-1:0]     bias_array,
    input  logic [NUM_UNITS-1:0][WIDTH-1:0]     a_in_array,
    input  logic [NUM_UNITS-1:0][WIDTH-1:0]     b_in_array,
    input  logic                                a_valid,
    output logic                                a_ready,
    output logic [NUM_UNITS-1:0][WIDTH-1:0]     result_out,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                busy,
    output logic                                done,
    output logic                                err
);
    localparam int LW = $clog2(MAX_LEN) + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, FINISH, OUTPUT} state_t;

    state_t          state_q;
    logic [LW-1:0]   len_q, cnt_q, cnt_nxt;
    logic [1:0]      mode_q;
    logic            a_ready_q, out_valid_q, busy_q, err_q;
    logic            len_ok, load, acc_en, finish;

    assign len_ok  = (length != '0) && (length <= LW'(MAX_LEN));
    assign cnt_nxt = cnt_q + LW'(1);
    assign load    = (state_q == IDLE) && start && len_ok;
    assign acc_en  = (state_q == ACCUM) && a_valid;
    assign finish  = (state_q == FINISH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= 2'd0;
            a_ready_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            len_q     <= length;
                            mode_q    <= act_mode;
                            cnt_q     <= '0;
                            a_ready_q <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= ACCUM;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (a_valid) begin
                        cnt_q <= cnt_nxt;
                        if (cnt_nxt == len_q) begin
                            a_ready_q <= 1'b0;
                            state_q   <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    out_valid_q <= 1'b1;
                    state_q     <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    genvar i;
    generate
        for (i = 0; i < NUM_UNITS; i++) begin : g_lane
            dot_product_lane #(
                .WIDTH    (WIDTH),
                .MAX_LEN  (MAX_LEN),
                .FRAC_BITS(FRAC_BITS)
            ) u_lane (
                .clk    (clk),
                .reset  (reset),
                .load   (load),
                .en     (active_units[i]),
                .bias_in(bias_array[i]),
                .acc_en (acc_en),
                .a      (a_in_array[i]),
                .b      (b_in_array[i]),
                .finish (finish),
                .mode   (mode_q),
                .result (result_out[i])
            );
        end
    endgenerate

    assign a_ready   = a_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign err       = err_q;
    // Handshake-cycle pulse; out_valid_q is cleared by reset so done is too.
    assign done      = out_valid_q && out_ready;
endmodule

// File: doc/dot_product_layer_unit.md
DOT_PRODUCT_LAYER_UNIT -- requirements
Module: dot_product_layer_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16: signed fixed-point operand/result width.
REQ-002 SHALL have parameter NUM_UNITS, default 16: parallel lanes (output neurons).
REQ-003 SHALL have parameter MAX_LEN, default 16: maximum dot-product length in beats.
REQ-004 SHALL have parameter FRAC_BITS, default 8: fractional bits of all operands and results.
REQ-005 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: begin operation; sampled only in IDLE.
REQ-008 SHALL have port length, input, $clog2(MAX_LEN)+1: beat count; latched at start.
REQ-009 SHALL have port act_mode, input, 2: 0 none, 1 ReLU, 2 leaky ReLU (x>>>3 when negative), 3 reserved (treated as none); latched at start.
REQ-010 SHALL have port active_units, input, NUM_UNITS: lane enables; latched at start.
REQ-011 SHALL have port bias_array, input, NUM_UNITS x WIDTH: per-lane bias; latched at start.
REQ-012 SHALL have ports a_in_array and b_in_array, input, NUM_UNITS x WIDTH each: per-lane operands of one beat.
REQ-013 SHALL have ports a_valid input 1 and a_ready output 1: operand beat handshake.
REQ-014 SHALL have ports result_out output NUM_UNITS x WIDTH, out_valid output 1, out_ready input 1: result handshake.
REQ-015 SHALL have outputs busy (1, high outside IDLE), done (1, one-cycle pulse), err (1, one-cycle pulse).

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, FINISH, OUTPUT.
REQ-017 IDLE: start with 1<=length<=MAX_LEN SHALL latch config, clear accumulators and beat counter, go to ACCUM.
REQ-018 IDLE: start with length==0 or length>MAX_LEN SHALL pulse err next cycle and remain IDLE.
REQ-019 ACCUM: a_ready SHALL be 1; each a_valid&&a_ready beat SHALL add signed a*b into each active lane's accumulator and increment the beat counter.
REQ-020 Accumulator width SHALL be 2*WIDTH+$clog2(MAX_LEN)+1 bits; no wrap possible within MAX_LEN beats.
REQ-021 After the length-th accepted beat, SHALL enter FINISH next cycle; a_ready SHALL be 0 outside ACCUM.
REQ-022 FINISH (one cycle): per lane, SHALL compute (acc + (bias<<<FRAC_BITS))>>>FRAC_BITS (arithmetic, truncation toward -inf), apply act_mode, saturate to signed WIDTH range, register into result_out, enter OUTPUT.
REQ-023 Inactive lanes SHALL produce result 0 regardless of operands or bias.
REQ-024 OUTPUT: out_valid SHALL be 1 and result_out stable until out_valid&&out_ready; on that cycle SHALL pulse done and return to IDLE next cycle.
REQ-025 Latency: out_valid SHALL rise 2 cycles after the clock edge accepting the last beat (edge+1 FINISH, edge+2 OUTPUT with out_valid registered).
REQ-026 start SHALL be ignored when not in IDLE; latched config SHALL not change mid-operation.
REQ-027 a_valid gaps SHALL stall ACCUM without state loss; out_ready low SHALL hold OUTPUT indefinitely.
REQ-028 result_out SHALL hold its last value in IDLE until the next FINISH.

Reset
REQ-029 reset low SHALL asynchronously force IDLE, clear accumulators, counter, result_out to 0, and set a_ready, out_valid, busy, done, err to 0.
REQ-030 reset assertion mid-operation SHALL abort without emitting done or out_valid; first start after release SHALL behave as from power-up.

Verification
REQ-031 Lane0 a=0x0100, b=0x0200, length=3, bias=0x0100, act_mode=0, continuous a_valid -> result_out[0]=0x0700, out_valid 2 cycles after third beat, done one pulse.
REQ-032 Lane0 a=0x0100, b=0xFE00 (-2.0), length=2, bias=0, act_mode=1 -> 0x0000; act_mode=2 -> 0xFF80 (-0.5); act_mode=0 -> 0xFC00.
REQ-033 Lane0 a=b=0x7FFF, length=16, bias=0x7FFF -> 0x7FFF saturated; a=0x7FFF, b=0x8000 -> 0x8000.
REQ-034 length=0 and length=MAX_LEN+1 -> err pulse, busy stays 0, a_ready stays 0; active_units=0x0001 -> lanes 1..15 read 0.
REQ-035 a_valid toggled randomly, out_ready held low 10 cycles -> same result as continuous; result_out stable and out_valid high throughout stall; start pulses during busy ignored.
REQ-036 reset pulsed low during ACCUM beat 2 -> all outputs 0 immediately; subsequent clean run gives the REQ-031 result.
